// File: rtl/uart_cmd_decode_pkg.sv
// Shared constants for the UART command path: frame codes, parser state
// encoding and the timeout length selected for silicon or simulation builds.
package uart_cmd_decode_pkg;

  localparam logic [7:0] HEAD   = 8'h5A;
  localparam logic [7:0] CMD_WR = 8'h55;
  localparam logic [7:0] CMD_RD = 8'hAA;

  // UART receiver timing; the parser timeout is about two byte times at this rate
  localparam int CLK_HZ     = 50_000_000;
  localparam int UART_BAUD  = 9600;
  localparam int BAUD_END   = CLK_HZ / UART_BAUD;

  localparam bit SIM        = 1'b0;
  localparam int TO_END_SYN = 104160;
  localparam int TO_END_SIM = 300;
  localparam int TO_END_SEL = SIM ? TO_END_SIM : TO_END_SYN;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    CMD  = 3'b010,
    DATA = 3'b100
  } state_t;

endpackage

// File: rtl/uart_cmd_decode.sv
// Framed command parser behind the UART receiver: pushes write payload into the
// SDRAM write FIFO and raises write/read trigger pulses for the arbiter.
module uart_cmd_decode
  import uart_cmd_decode_pkg::*;
#(
  parameter int WR_LEN = 4,
  parameter int TO_END = TO_END_SEL,
  parameter int TO_W   = 17
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       uart_flag,
  input  logic [7:0] uart_data,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_data,
  output logic       wr_trig,
  output logic       rd_trig,
  output logic       frame_err
);

  state_t          state_r;
  logic [3:0]      byte_cnt_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            wr_pend_r;
  logic            to_hit_s;

  assign to_hit_s = (to_cnt_r == TO_W'(TO_END));

  // Parser FSM with registered pulse outputs and inter-byte timeout
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_r     <= IDLE;
      byte_cnt_r  <= 4'd0;
      to_cnt_r    <= '0;
      wr_pend_r   <= 1'b0;
      wfifo_wr_en <= 1'b0;
      wfifo_data  <= 8'h00;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      wfifo_wr_en <= 1'b0;
      rd_trig     <= 1'b0;
      frame_err   <= 1'b0;
      // wr_trig trails the last push by one cycle so the FIFO is complete
      wr_trig     <= wr_pend_r;
      wr_pend_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          to_cnt_r <= '0;
          if (uart_flag && (uart_data == HEAD)) begin
            state_r <= CMD;
          end else begin
            state_r <= IDLE;
          end
        end
        CMD: begin
          if (uart_flag) begin
            to_cnt_r <= '0;
            case (uart_data)
              CMD_WR: begin
                byte_cnt_r <= 4'd0;
                state_r    <= DATA;
              end
              CMD_RD: begin
                rd_trig <= 1'b1;
                state_r <= IDLE;
              end
              default: begin
                frame_err <= 1'b1;
                state_r   <= IDLE;
              end
            endcase
          end else if (to_hit_s) begin
            to_cnt_r  <= '0;
            frame_err <= 1'b1;
            state_r   <= IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        DATA: begin
          if (uart_flag) begin
            to_cnt_r    <= '0;
            wfifo_data  <= uart_data;
            wfifo_wr_en <= 1'b1;
            if (byte_cnt_r == 4'(WR_LEN - 1)) begin
              byte_cnt_r <= 4'd0;
              wr_pend_r  <= 1'b1;
              state_r    <= IDLE;
            end else begin
              byte_cnt_r <= byte_cnt_r + 4'd1;
            end
          end else if (to_hit_s) begin
            to_cnt_r   <= '0;
            byte_cnt_r <= 4'd0;
            frame_err  <= 1'b1;
            state_r    <= IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        default: begin
          to_cnt_r   <= '0;
          byte_cnt_r <= 4'd0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decode.sv
// Directed bench for uart_cmd_decode: write, read, bad command, timeout,
// timeout boundary and mid-frame reset scenarios.
module tb_uart_cmd_decode;
  import uart_cmd_decode_pkg::*;

  localparam int TO = TO_END_SIM;

  logic       sclk;
  logic       s_rst_n;
  logic       uart_flag;
  logic [7:0] uart_data;
  logic       wfifo_wr_en;
  logic [7:0] wfifo_data;
  logic       wr_trig;
  logic       rd_trig;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  uart_cmd_decode #(.WR_LEN(4), .TO_END(TO), .TO_W(17)) dut (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .uart_flag   (uart_flag),
    .uart_data   (uart_data),
    .wfifo_wr_en (wfifo_wr_en),
    .wfifo_data  (wfifo_data),
    .wr_trig     (wr_trig),
    .rd_trig     (rd_trig),
    .frame_err   (frame_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Strobe one byte; returns on the falling edge after it was sampled
  task automatic send_byte(input logic [7:0] b);
    @(negedge sclk);
    uart_flag = 1'b1;
    uart_data = b;
    @(negedge sclk);
    uart_flag = 1'b0;
  endtask

  task automatic test_reset();
    s_rst_n = 1'b0; uart_flag = 1'b0; uart_data = 8'h00;
    repeat (3) @(negedge sclk);
    total++;
    if ({wfifo_wr_en, wfifo_data, wr_trig, rd_trig, frame_err} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got %b required 0", {wfifo_wr_en, wfifo_data, wr_trig, rd_trig, frame_err});
    end
    s_rst_n = 1'b1;
    repeat (2) @(negedge sclk);
  endtask

  // Sends the four payload bytes after 5A 55 and checks pushes and wr_trig
  task automatic write_payload(input logic [31:0] pl, input string tag);
    logic [7:0] b;
    send_byte(HEAD);
    send_byte(CMD_WR);
    for (int i = 0; i < 4; i++) begin
      b = pl[31 - 8*i -: 8];
      send_byte(b);
      total++;
      if (wfifo_wr_en !== 1'b1 || wfifo_data !== b || wr_trig !== 1'b0 || frame_err !== 1'b0) begin
        bad++;
        $display("FAIL %s_push%0d: got en=%b data=%h trig=%b err=%b required en=1 data=%h trig=0 err=0",
                 tag, i, wfifo_wr_en, wfifo_data, wr_trig, frame_err, b);
      end
    end
    @(negedge sclk);
    total++;
    if (wr_trig !== 1'b1 || wfifo_wr_en !== 1'b0 || wfifo_data !== pl[7:0]) begin
      bad++;
      $display("FAIL %s_wr_trig: got trig=%b en=%b data=%h required trig=1 en=0 data=%h",
               tag, wr_trig, wfifo_wr_en, wfifo_data, pl[7:0]);
    end
    @(negedge sclk);
    total++;
    if (wr_trig !== 1'b0) begin
      bad++;
      $display("FAIL %s_wr_trig_width: got %b required 0", tag, wr_trig);
    end
  endtask

  task automatic test_write();
    write_payload(32'h11223344, "write");
  endtask

  task automatic test_read();
    send_byte(HEAD);
    total++;
    if (rd_trig !== 1'b0 || wfifo_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL read_head: got rd=%b en=%b required 0 0", rd_trig, wfifo_wr_en);
    end
    send_byte(CMD_RD);
    total++;
    if (rd_trig !== 1'b1 || wfifo_wr_en !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL read_trig: got rd=%b en=%b err=%b required 1 0 0", rd_trig, wfifo_wr_en, frame_err);
    end
    @(negedge sclk);
    total++;
    if (rd_trig !== 1'b0 || wr_trig !== 1'b0) begin
      bad++;
      $display("FAIL read_trig_width: got rd=%b wr=%b required 0 0", rd_trig, wr_trig);
    end
  endtask

  task automatic test_bad_cmd();
    send_byte(8'h00);
    send_byte(8'h13);
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL idle_junk: got err=%b required 0", frame_err);
    end
    send_byte(HEAD);
    send_byte(8'h7E);
    total++;
    if (frame_err !== 1'b1 || rd_trig !== 1'b0) begin
      bad++;
      $display("FAIL bad_cmd_err: got err=%b rd=%b required 1 0", frame_err, rd_trig);
    end
    // HEAD in command position is an error, not a resync
    send_byte(HEAD);
    send_byte(HEAD);
    total++;
    if (frame_err !== 1'b1) begin
      bad++;
      $display("FAIL head_in_cmd: got err=%b required 1", frame_err);
    end
    send_byte(CMD_RD);
    total++;
    if (rd_trig !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL back_in_idle: got rd=%b err=%b required 0 0", rd_trig, frame_err);
    end
    test_read();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    send_byte(HEAD);
    send_byte(CMD_WR);
    send_byte(8'h11);
    send_byte(8'h22);
    total++;
    if (wfifo_wr_en !== 1'b1 || wfifo_data !== 8'h22) begin
      bad++;
      $display("FAIL to_push: got en=%b data=%h required 1 22", wfifo_wr_en, wfifo_data);
    end
    for (int k = 1; k <= TO; k++) begin
      @(negedge sclk);
      if (frame_err !== 1'b0 || wr_trig !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL to_early: got %0d pulse cycles required 0", early);
    end
    @(negedge sclk);
    total++;
    if (frame_err !== 1'b1 || wr_trig !== 1'b0) begin
      bad++;
      $display("FAIL to_err: got err=%b trig=%b required 1 0", frame_err, wr_trig);
    end
    @(negedge sclk);
    total++;
    if (frame_err !== 1'b0 || wfifo_data !== 8'h22) begin
      bad++;
      $display("FAIL to_after: got err=%b data=%h required 0 22", frame_err, wfifo_data);
    end
    test_read();
  endtask

  task automatic test_to_boundary();
    send_byte(HEAD);
    send_byte(CMD_WR);
    send_byte(8'h11);
    // next strobe is sampled on the edge where the counter equals TO_END
    repeat (TO - 1) @(negedge sclk);
    send_byte(8'h22);
    total++;
    if (wfifo_wr_en !== 1'b1 || wfifo_data !== 8'h22 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL boundary_byte: got en=%b data=%h err=%b required 1 22 0", wfifo_wr_en, wfifo_data, frame_err);
    end
    send_byte(8'h33);
    send_byte(8'h44);
    @(negedge sclk);
    total++;
    if (wr_trig !== 1'b1 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL boundary_trig: got trig=%b err=%b required 1 0", wr_trig, frame_err);
    end
    @(negedge sclk);
  endtask

  task automatic test_mid_reset();
    send_byte(HEAD);
    send_byte(CMD_WR);
    send_byte(8'h11);
    s_rst_n = 1'b0;
    #1;
    total++;
    if (wfifo_wr_en !== 1'b0 || wfifo_data !== 8'h00) begin
      bad++;
      $display("FAIL async_reset: got en=%b data=%h required 0 00", wfifo_wr_en, wfifo_data);
    end
    @(negedge sclk);
    s_rst_n = 1'b1;
    @(negedge sclk);
    write_payload(32'hA1A2A3A4, "post_reset");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_timeout();
    test_to_boundary();
    test_mid_reset();
    repeat (3) @(negedge sclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decode.md
Name: uart_cmd_decode

Overview:
- Byte-stream command parser sitting directly downstream of the UART receiver.
- Consumes the receiver's `rx_data`/`po_flag` byte strobe.
- Recognises framed commands: header, then command byte, then payload for writes.
- Pushes write payload bytes into the SDRAM write FIFO and issues single-cycle write/read trigger pulses to the SDRAM arbiter.
- Inter-byte timeout and malformed-frame detection keep the parser from hanging on a broken host stream.

Parameters:
- HEAD, 8'h5A, frame header byte
- CMD_WR, 8'h55, write command code
- CMD_RD, 8'hAA, read command code
- WR_LEN, 4, payload bytes per write frame (1..15)
- TO_END, 104160, inter-byte timeout in sclk cycles (about 2 byte times at 9600 baud, 50 MHz); simulation builds use 300
- TO_W, 17, timeout counter width; must hold TO_END

Ports:
- sclk  input  1  system clock
- s_rst_n  input  1  asynchronous active-low reset
- uart_flag  input  1  one-cycle byte-valid strobe from UART receiver
- uart_data  input  8  received byte, valid when uart_flag=1
- wfifo_wr_en  output  1  write-FIFO push strobe, one cycle per payload byte
- wfifo_data  output  8  payload byte, valid with wfifo_wr_en
- wr_trig  output  1  one-cycle pulse: full write payload is in FIFO
- rd_trig  output  1  one-cycle pulse: read command received
- frame_err  output  1  one-cycle pulse: bad command byte or timeout

Behaviour:
- Interface: one clock, sclk; reset s_rst_n is asynchronous, active-low. All flops reset to 0; state resets to IDLE.
- States:
  - IDLE: uart_flag with uart_data==HEAD -> CMD. Any other byte is ignored silently; no frame_err.
  - CMD, on uart_flag:
    - CMD_WR -> DATA, byte_cnt cleared.
    - CMD_RD -> rd_trig pulses the next cycle; -> IDLE.
    - any other value -> frame_err pulses the next cycle; -> IDLE.
  - DATA, on uart_flag:
    - wfifo_data<=uart_data and wfifo_wr_en=1 in the next cycle; byte_cnt increments.
    - On the WR_LEN-th byte -> IDLE, and wr_trig pulses one cycle after that byte's wfifo_wr_en. So wr_trig is exactly 2 cycles after the last uart_flag, and the FIFO already holds all bytes.
- Latency:
  - wfifo_wr_en, rd_trig and frame_err are registered, 1 cycle after uart_flag.
  - wr_trig is 2 cycles after the last payload uart_flag.
- Timeout counter:
  - Runs only in CMD or DATA; clears on every uart_flag and whenever in IDLE.
  - Reaching TO_END -> frame_err pulse next cycle, state -> IDLE, byte_cnt cleared.
  - Bytes already pushed to the FIFO are not retracted; no wr_trig is issued for that frame.
- Simultaneous events:
  - uart_flag in the same cycle as counter==TO_END: the byte wins, is processed normally, and the counter clears.
  - A HEAD byte in CMD state is treated as an invalid command (frame_err), not as a resync.
- Outputs are mutually exclusive pulses, except that wfifo_wr_en never coincides with wr_trig for the same frame.
- wfifo_data holds its last value when wfifo_wr_en=0.
- Reset mid-frame: immediate return to IDLE; all pulses deassert asynchronously; partial frame discarded.
- No backpressure: the write FIFO is sized by the system so it never fills at UART rate.

Decomposition:
- Shared package/header holds HEAD, CMD_WR, CMD_RD, and the state encodings (IDLE=3'b001, CMD=3'b010, DATA=3'b100, one-hot).
- The same header carries the SIM selection of TO_END, alongside the UART receiver's baud constant.
- Single flat module; no sub-module is natural.

Test Plan:
- Frame 5A 55 11 22 33 44 -> four wfifo_wr_en pulses with data 11, 22, 33, 44; wr_trig 2 cycles after the last strobe; no frame_err.
- Frame 5A AA -> rd_trig one cycle after the AA strobe; no FIFO writes.
- Bytes 00 13 then 5A 7E -> first two ignored silently; frame_err one cycle after 7E; state returns to IDLE.
- 5A 55 11 22 then silence -> two FIFO pushes, frame_err at TO_END+1 cycles after the 22 strobe, no wr_trig; a following 5A AA produces rd_trig.
- Byte strobe landing exactly on the TO_END cycle -> processed, no frame_err.
- Assert s_rst_n=0 after 5A 55 11, then release and send 5A 55 A1 A2 A3 A4 -> only A1..A4 pushed; one wr_trig.
